// File: rtl/chipmunk_pkg.sv
// chipmunk_pkg
//   Constants shared between the chipmunk CPU and its memory-side responder:
//   bus widths, the default I/O window base, the halt opcode and the
//   responder's state encoding.
//   No ports (package).
package chipmunk_pkg;

    localparam int CHIP_ADDR_W = 12;
    localparam int CHIP_DATA_W = 8;

    localparam logic [CHIP_ADDR_W-1:0] CHIP_IO_BASE = 12'hFF0;
    localparam logic [CHIP_DATA_W-1:0] CHIP_HALT_OP = 8'h83;

    // Responder states, kept as plain constants so older tools can read them
    typedef logic [1:0] chip_state_t;
    localparam chip_state_t ST_LOAD = 2'd0;
    localparam chip_state_t ST_RUN  = 2'd1;
    localparam chip_state_t ST_HALT = 2'd2;

endpackage

// File: rtl/chipmunk_if.sv
// chipmunk_if
//   CPU bus plus program-loader handshake between the chipmunk CPU / loader
//   side (master) and the memory responder (slave).
//   Signals:
//     addrBus, dataBusWrite, weMem, done   CPU -> memory
//     dataBus, cpuResetN                   memory -> CPU
//     loadValid, loadData, loadLast        loader -> memory
//     loadReady                            memory -> loader
interface chipmunk_if
    import chipmunk_pkg::*;
#(
    parameter int ADDR_W = CHIP_ADDR_W,
    parameter int DATA_W = CHIP_DATA_W
) ();

    logic [ADDR_W-1:0] addrBus;
    logic [DATA_W-1:0] dataBusWrite;
    logic              weMem;
    logic              done;
    logic [DATA_W-1:0] dataBus;
    logic              cpuResetN;
    logic              loadValid;
    logic [DATA_W-1:0] loadData;
    logic              loadLast;
    logic              loadReady;

    modport master (
        output addrBus, dataBusWrite, weMem, done, loadValid, loadData, loadLast,
        input  dataBus, cpuResetN, loadReady
    );

    modport slave (
        input  addrBus, dataBusWrite, weMem, done, loadValid, loadData, loadLast,
        output dataBus, cpuResetN, loadReady
    );

endinterface

// File: rtl/chipmunk_ram.sv
// chipmunk_ram
//   DEPTH x DATA_W storage with one asynchronous read port and one
//   synchronous write port. Contents are never cleared by reset.
//   Ports:
//     clk        write clock
//     we_i       write enable
//     waddr_i    write address
//     wdata_i    write data
//     raddr_i    read address
//     rdata_o    read data, combinational from raddr_i
module chipmunk_ram
    import chipmunk_pkg::*;
#(
    parameter int DEPTH  = 4096,
    parameter int DATA_W = CHIP_DATA_W,
    parameter int AW     = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we_i,
    input  logic [AW-1:0]     waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic [AW-1:0]     raddr_i,
    output logic [DATA_W-1:0] rdata_o
);

    logic [DATA_W-1:0] mem_q [DEPTH];

    // Single write port; the loader and the CPU are already muxed upstream
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/chipmunk_mem.sv
// chipmunk_mem
//   Memory-side responder for the chipmunk CPU bus. A byte-stream loader
//   fills RAM while the CPU is held in reset, then the CPU runs against RAM
//   and a two-byte I/O window (output register, free-running tick) until it
//   reports done and the responder halts.
//   Ports:
//     clk          system clock, all state on rising edge
//     reset        asynchronous, active-low
//     bus          chipmunk_if slave: CPU bus + loader handshake
//     reloadStart  pulse: return to LOAD from RUN or HALT
//     outPort      I/O output register
//     outStrobe    one-cycle pulse per outPort write
//     halted       high while halted
module chipmunk_mem
    import chipmunk_pkg::*;
#(
    parameter int                ADDR_W  = CHIP_ADDR_W,
    parameter int                DATA_W  = CHIP_DATA_W,
    parameter int                DEPTH   = 4096,
    parameter logic [ADDR_W-1:0] IO_BASE = CHIP_IO_BASE,
    parameter logic [DATA_W-1:0] HALT_OP = CHIP_HALT_OP
) (
    input  logic              clk,
    input  logic              reset,
    chipmunk_if.slave         bus,
    input  logic              reloadStart,
    output logic [DATA_W-1:0] outPort,
    output logic              outStrobe,
    output logic              halted
);

    localparam int                RAM_AW    = $clog2(DEPTH);
    localparam logic [ADDR_W:0]   DEPTH_X   = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W-1:0] TICK_ADDR = IO_BASE + ADDR_W'(1);

    chip_state_t       state_q, state_d;
    logic [ADDR_W-1:0] loadAddr_q, loadAddr_d;
    logic [DATA_W-1:0] outPort_q, outPort_d;
    logic              outStrobe_q, outStrobe_d;
    logic [7:0]        tick_q, tick_d;
    logic              cpuResetN_q;

    logic              inLoad, inRun;
    logic              loadXfer, cpuWr;
    logic              addrIsOut, addrIsTick, addrInRam;
    logic              ramWe;
    logic [RAM_AW-1:0] ramWaddr;
    logic [DATA_W-1:0] ramWdata, ramRdata;

    assign inLoad     = (state_q == ST_LOAD);
    assign inRun      = (state_q == ST_RUN);
    assign loadXfer   = inLoad && bus.loadValid;
    assign cpuWr      = inRun && bus.weMem;
    assign addrIsOut  = (bus.addrBus == IO_BASE);
    assign addrIsTick = (bus.addrBus == TICK_ADDR);
    // The I/O window wins over RAM if the two ever overlap
    assign addrInRam  = ({1'b0, bus.addrBus} < DEPTH_X) && !addrIsOut && !addrIsTick;

    chipmunk_ram #(
        .DEPTH  (DEPTH),
        .DATA_W (DATA_W),
        .AW     (RAM_AW)
    ) u_ram (
        .clk     (clk),
        .we_i    (ramWe),
        .waddr_i (ramWaddr),
        .wdata_i (ramWdata),
        .raddr_i (bus.addrBus[RAM_AW-1:0]),
        .rdata_o (ramRdata)
    );

    // Loader and CPU never write in the same state, so a simple priority
    // mux is enough to share the single RAM write port
    always_comb begin
        ramWe    = 1'b0;
        ramWaddr = bus.addrBus[RAM_AW-1:0];
        ramWdata = bus.dataBusWrite;
        if (loadXfer) begin
            ramWe    = 1'b1;
            ramWaddr = loadAddr_q[RAM_AW-1:0];
            ramWdata = bus.loadData;
        end else if (cpuWr && addrInRam) begin
            ramWe = 1'b1;
        end
    end

    // CPU read data: only RUN exposes memory and I/O, everything else
    // returns the halt opcode so a CPU coming out of reset early spins safely
    always_comb begin
        bus.dataBus = HALT_OP;
        if (inRun) begin
            if (addrIsOut) begin
                bus.dataBus = outPort_q;
            end else if (addrIsTick) begin
                bus.dataBus = DATA_W'(tick_q);
            end else if (addrInRam) begin
                bus.dataBus = ramRdata;
            end
        end
    end

    // Next-state: loader progress, RUN/HALT transitions, tick and I/O.
    // reloadStart is checked before done so a reload always wins.
    always_comb begin
        state_d     = state_q;
        loadAddr_d  = loadAddr_q;
        tick_d      = tick_q;
        outPort_d   = outPort_q;
        outStrobe_d = cpuWr && addrIsOut;
        if (cpuWr && addrIsOut) begin
            outPort_d = bus.dataBusWrite;
        end
        case (state_q)
            ST_LOAD: begin
                if (loadXfer) begin
                    // Stop at the last implemented byte rather than wrapping
                    if (bus.loadLast || (loadAddr_q == LAST_ADDR)) begin
                        state_d = ST_RUN;
                    end else begin
                        loadAddr_d = loadAddr_q + ADDR_W'(1);
                    end
                end
            end
            ST_RUN: begin
                if (reloadStart) begin
                    state_d    = ST_LOAD;
                    loadAddr_d = '0;
                    tick_d     = '0;
                end else begin
                    tick_d = tick_q + 8'd1;
                    if (bus.done) begin
                        state_d = ST_HALT;
                    end
                end
            end
            ST_HALT: begin
                if (reloadStart) begin
                    state_d    = ST_LOAD;
                    loadAddr_d = '0;
                    tick_d     = '0;
                end
            end
            default: begin
                state_d    = ST_LOAD;
                loadAddr_d = '0;
                tick_d     = '0;
            end
        endcase
    end

    // State registers; cpuResetN follows the next state so it releases the
    // CPU in the cycle right after the final loader transfer
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_LOAD;
            loadAddr_q  <= '0;
            outPort_q   <= '0;
            outStrobe_q <= 1'b0;
            tick_q      <= '0;
            cpuResetN_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            loadAddr_q  <= loadAddr_d;
            outPort_q   <= outPort_d;
            outStrobe_q <= outStrobe_d;
            tick_q      <= tick_d;
            cpuResetN_q <= (state_d != ST_LOAD);
        end
    end

    assign bus.cpuResetN = cpuResetN_q;
    assign bus.loadReady = inLoad;
    assign outPort       = outPort_q;
    assign outStrobe     = outStrobe_q;
    assign halted        = (state_q == ST_HALT);

endmodule

// File: tb/tb_chipmunk_mem.sv
// tb_chipmunk_mem
//   Self-checking bench for chipmunk_mem. A main instance (2048 bytes) is
//   tracked by a behavioural model; a small 16-byte instance covers the
//   loader end-of-memory case.
module tb_chipmunk_mem;

    localparam int         DEPTH_MAIN  = 2048;
    localparam int         DEPTH_SMALL = 16;
    localparam logic [11:0] IOB = 12'hFF0;
    localparam logic [7:0]  HOP = 8'h83;

    logic       clk = 1'b0;
    logic       reset;
    logic       reloadStart, reloadStartS;
    logic [7:0] outPort, outPortS;
    logic       outStrobe, outStrobeS;
    logic       halted, haltedS;

    chipmunk_if #(.ADDR_W(12), .DATA_W(8)) busM ();
    chipmunk_if #(.ADDR_W(12), .DATA_W(8)) busS ();

    chipmunk_mem #(
        .ADDR_W(12), .DATA_W(8), .DEPTH(DEPTH_MAIN), .IO_BASE(IOB), .HALT_OP(HOP)
    ) dut (
        .clk(clk), .reset(reset), .bus(busM), .reloadStart(reloadStart),
        .outPort(outPort), .outStrobe(outStrobe), .halted(halted)
    );

    chipmunk_mem #(
        .ADDR_W(12), .DATA_W(8), .DEPTH(DEPTH_SMALL), .IO_BASE(IOB), .HALT_OP(HOP)
    ) dutS (
        .clk(clk), .reset(reset), .bus(busS), .reloadStart(reloadStartS),
        .outPort(outPortS), .outStrobe(outStrobeS), .halted(haltedS)
    );

    always #5 clk = ~clk;

    // Behavioural model of the main instance
    typedef enum {M_LOAD, M_RUN, M_HALT} mode_t;
    mode_t mMode;
    int    mLoadAddr;
    int    mTick;
    int    mOutPort;
    bit    mStrobe;
    int    mMem   [DEPTH_MAIN];
    bit    mKnown [DEPTH_MAIN];

    int checks = 0;
    int errors = 0;

    logic [7:0] progBytes [6];

    task automatic modelReset();
        mMode     = M_LOAD;
        mLoadAddr = 0;
        mTick     = 0;
        mOutPort  = 0;
        mStrobe   = 1'b0;
    endtask

    // What the CPU should see on dataBus for a given address right now
    function automatic logic [7:0] modelRead(input logic [11:0] a);
        int ai;
        ai = int'(a);
        if (mMode != M_RUN) return HOP;
        if (ai == int'(IOB)) return 8'(mOutPort);
        if (ai == int'(IOB) + 1) return 8'(mTick);
        if (ai < DEPTH_MAIN) return 8'(mMem[ai]);
        return HOP;
    endfunction

    // Apply one clock edge's worth of effects, using the inputs at the edge
    task automatic modelEdge();
        int a;
        bit ioWr;
        if (!reset) return;
        a    = int'(busM.addrBus);
        ioWr = 1'b0;
        case (mMode)
            M_LOAD: begin
                if (busM.loadValid) begin
                    mMem[mLoadAddr]   = int'(busM.loadData);
                    mKnown[mLoadAddr] = 1'b1;
                    if (busM.loadLast || mLoadAddr == DEPTH_MAIN - 1) mMode = M_RUN;
                    else mLoadAddr++;
                end
            end
            M_RUN: begin
                if (busM.weMem) begin
                    if (a == int'(IOB)) begin
                        mOutPort = int'(busM.dataBusWrite);
                        ioWr     = 1'b1;
                    end else if (a < DEPTH_MAIN) begin
                        mMem[a]   = int'(busM.dataBusWrite);
                        mKnown[a] = 1'b1;
                    end
                end
                if (reloadStart) begin
                    mMode = M_LOAD; mLoadAddr = 0; mTick = 0;
                end else begin
                    mTick = (mTick + 1) % 256;
                    if (busM.done) mMode = M_HALT;
                end
            end
            default: begin
                if (reloadStart) begin
                    mMode = M_LOAD; mLoadAddr = 0; mTick = 0;
                end
            end
        endcase
        mStrobe = ioWr;
    endtask

    task automatic step();
        @(posedge clk);
        modelEdge();
        #1;
    endtask

    task automatic peek(input logic [11:0] a, output logic [7:0] d);
        busM.addrBus = a;
        #1;
        d = busM.dataBus;
    endtask

    task automatic setIdle();
        busM.addrBus = '0; busM.dataBusWrite = '0; busM.weMem = 1'b0; busM.done = 1'b0;
        busM.loadValid = 1'b0; busM.loadData = '0; busM.loadLast = 1'b0;
        busS.addrBus = '0; busS.dataBusWrite = '0; busS.weMem = 1'b0; busS.done = 1'b0;
        busS.loadValid = 1'b0; busS.loadData = '0; busS.loadLast = 1'b0;
        reloadStart = 1'b0; reloadStartS = 1'b0;
    endtask

    task automatic test_reset();
        logic [7:0] d;
        setIdle();
        reset = 1'b0;
        modelReset();
        for (int i = 0; i < DEPTH_MAIN; i++) mKnown[i] = 1'b0;
        repeat (2) step();
        checks++;
        if ({busM.cpuResetN, busM.loadReady, halted, outStrobe} !== 4'b0100) begin
            errors++;
            $display("FAIL reset_ctrl got %b exp 0100", {busM.cpuResetN, busM.loadReady, halted, outStrobe});
        end
        checks++;
        if (outPort !== 8'h00) begin errors++; $display("FAIL reset_outport got %h exp 00", outPort); end
        peek(12'h002, d);
        checks++;
        if (d !== HOP) begin errors++; $display("FAIL reset_read got %h exp %h", d, HOP); end
        reset = 1'b1;
        step();
        checks++;
        if ({busM.cpuResetN, busM.loadReady} !== 2'b01) begin
            errors++; $display("FAIL reset_release got %b exp 01", {busM.cpuResetN, busM.loadReady});
        end
    endtask

    task automatic test_load();
        logic [7:0] d;
        progBytes = '{8'h00, 8'h08, 8'h21, 8'h05, 8'h98, 8'h83};
        for (int i = 0; i < 6; i++) begin
            busM.loadValid = 1'b1;
            busM.loadData  = progBytes[i];
            busM.loadLast  = (i == 5);
            step();
            if (i == 4) begin
                checks++;
                if ({busM.cpuResetN, busM.loadReady} !== 2'b01) begin
                    errors++; $display("FAIL load_before_last got %b exp 01", {busM.cpuResetN, busM.loadReady});
                end
            end
        end
        setIdle();
        checks++;
        if ({busM.cpuResetN, busM.loadReady, halted} !== 3'b100) begin
            errors++; $display("FAIL load_release got %b exp 100", {busM.cpuResetN, busM.loadReady, halted});
        end
        peek(12'h002, d);
        checks++;
        if (d !== 8'h21) begin errors++; $display("FAIL load_read002 got %h exp 21", d); end
        peek(12'h004, d);
        checks++;
        if (d !== 8'h98) begin errors++; $display("FAIL load_read004 got %h exp 98", d); end
    endtask

    task automatic test_ram_write();
        logic [7:0] d;
        busM.addrBus = 12'h100; busM.dataBusWrite = 8'h5A; busM.weMem = 1'b1;
        step();
        busM.weMem = 1'b0;
        peek(12'h100, d);
        checks++;
        if (d !== 8'h5A) begin errors++; $display("FAIL ram_write got %h exp 5a", d); end
        // 0x900 aliases 0x100 in the low address bits
        busM.addrBus = 12'h900; busM.dataBusWrite = 8'h77; busM.weMem = 1'b1;
        step();
        busM.weMem = 1'b0;
        peek(12'h900, d);
        checks++;
        if (d !== HOP) begin errors++; $display("FAIL unmapped_read got %h exp %h", d, HOP); end
        peek(12'h100, d);
        checks++;
        if (d !== 8'h5A) begin errors++; $display("FAIL unmapped_alias got %h exp 5a", d); end
    endtask

    task automatic test_io();
        logic [7:0] d, prev, e;
        bit sawWrap;
        busM.addrBus = IOB; busM.dataBusWrite = 8'h3C; busM.weMem = 1'b1;
        step();
        busM.weMem = 1'b0;
        checks++;
        if ({outStrobe, outPort} !== {1'b1, 8'h3C}) begin
            errors++; $display("FAIL io_write got %b/%h exp 1/3c", outStrobe, outPort);
        end
        peek(IOB, d);
        checks++;
        if (d !== 8'h3C) begin errors++; $display("FAIL io_read got %h exp 3c", d); end
        step();
        checks++;
        if (outStrobe !== 1'b0) begin errors++; $display("FAIL io_strobe_len got %b exp 0", outStrobe); end
        busM.addrBus = IOB + 12'd1; busM.dataBusWrite = 8'h11; busM.weMem = 1'b1;
        step();
        busM.weMem = 1'b0;
        checks++;
        if ({outStrobe, outPort} !== {1'b0, 8'h3C}) begin
            errors++; $display("FAIL io_tick_write got %b/%h exp 0/3c", outStrobe, outPort);
        end
        peek(IOB + 12'd1, prev);
        sawWrap = 1'b0;
        for (int i = 0; i < 260; i++) begin
            step();
            peek(IOB + 12'd1, d);
            e = modelRead(IOB + 12'd1);
            checks++;
            if (d !== e || d !== prev + 8'd1) begin
                errors++; $display("FAIL tick_count got %h exp %h", d, e);
            end
            if (prev == 8'hFF && d == 8'h00) sawWrap = 1'b1;
            prev = d;
        end
        checks++;
        if (sawWrap !== 1'b1) begin errors++; $display("FAIL tick_wrap got %b exp 1", sawWrap); end
        for (int k = 0; k < 4; k++) begin
            busM.addrBus = IOB; busM.dataBusWrite = 8'hA0 + 8'(k); busM.weMem = 1'b1;
            step();
            checks++;
            if ({outStrobe, outPort} !== {1'b1, 8'hA0 + 8'(k)}) begin
                errors++; $display("FAIL io_b2b got %b/%h exp 1/%h", outStrobe, outPort, 8'hA0 + 8'(k));
            end
        end
        busM.weMem = 1'b0;
        step();
        checks++;
        if ({outStrobe, outPort} !== {1'b0, 8'hA3}) begin
            errors++; $display("FAIL io_b2b_end got %b/%h exp 0/a3", outStrobe, outPort);
        end
    endtask

    function automatic logic [11:0] pickAddr();
        case ($urandom_range(0, 5))
            0, 1, 2: return 12'h200 + 12'($urandom_range(0, 15));
            3:       return IOB;
            4:       return IOB + 12'd1;
            default: return 12'h800 + 12'($urandom_range(0, 1000));
        endcase
    endfunction

    task automatic test_random();
        logic [7:0] d, e;
        logic [11:0] ra;
        for (int n = 0; n < 200; n++) begin
            ra = pickAddr();
            if (!(int'(ra) < DEPTH_MAIN && !mKnown[int'(ra)])) begin
                peek(ra, d);
                e = modelRead(ra);
                checks++;
                if (d !== e) begin errors++; $display("FAIL rand_read addr %h got %h exp %h", ra, d, e); end
            end
            busM.addrBus      = pickAddr();
            busM.dataBusWrite = 8'($urandom);
            busM.weMem        = ($urandom_range(0, 1) == 1);
            step();
            busM.weMem = 1'b0;
            checks++;
            if ({outStrobe, outPort} !== {mStrobe, 8'(mOutPort)}) begin
                errors++; $display("FAIL rand_io got %b/%h exp %b/%h", outStrobe, outPort, mStrobe, 8'(mOutPort));
            end
        end
    endtask

    task automatic test_halt();
        logic [7:0] d;
        busM.addrBus = 12'h101; busM.dataBusWrite = 8'h44; busM.weMem = 1'b1; busM.done = 1'b1;
        step();
        setIdle();
        checks++;
        if ({halted, busM.cpuResetN, busM.loadReady} !== 3'b110) begin
            errors++; $display("FAIL halt_enter got %b exp 110", {halted, busM.cpuResetN, busM.loadReady});
        end
        peek(12'h101, d);
        checks++;
        if (d !== HOP) begin errors++; $display("FAIL halt_read101 got %h exp %h", d, HOP); end
        peek(IOB, d);
        checks++;
        if (d !== HOP) begin errors++; $display("FAIL halt_readio got %h exp %h", d, HOP); end
        busM.addrBus = 12'h100; busM.dataBusWrite = 8'hEE; busM.weMem = 1'b1;
        step();
        busM.weMem = 1'b0;
        reloadStart = 1'b1;
        step();
        reloadStart = 1'b0;
        checks++;
        if ({halted, busM.cpuResetN, busM.loadReady} !== 3'b001) begin
            errors++; $display("FAIL halt_reload got %b exp 001", {halted, busM.cpuResetN, busM.loadReady});
        end
        busM.loadValid = 1'b1; busM.loadData = 8'hAA; busM.loadLast = 1'b0;
        step();
        busM.loadData = 8'hBB; busM.loadLast = 1'b1;
        step();
        setIdle();
        peek(12'h000, d);
        checks++;
        if (d !== 8'hAA) begin errors++; $display("FAIL reload_addr0 got %h exp aa", d); end
        peek(12'h100, d);
        checks++;
        if (d !== 8'h5A) begin errors++; $display("FAIL halt_write_ignored got %h exp 5a", d); end
        peek(12'h101, d);
        checks++;
        if (d !== 8'h44) begin errors++; $display("FAIL write_with_done got %h exp 44", d); end
        busM.loadValid = 1'b1; busM.loadData = 8'h99; busM.loadLast = 1'b1;
        step();
        setIdle();
        peek(12'h000, d);
        checks++;
        if (d !== 8'hAA) begin errors++; $display("FAIL load_in_run got %h exp aa", d); end
        reloadStart = 1'b1; busM.done = 1'b1;
        step();
        setIdle();
        checks++;
        if ({halted, busM.loadReady} !== 2'b01) begin
            errors++; $display("FAIL reload_vs_done got %b exp 01", {halted, busM.loadReady});
        end
        busM.loadValid = 1'b1; busM.loadData = 8'hC7; busM.loadLast = 1'b1;
        step();
        setIdle();
        peek(IOB + 12'd1, d);
        checks++;
        if (d !== 8'h00) begin errors++; $display("FAIL tick_cleared got %h exp 00", d); end
        peek(12'h000, d);
        checks++;
        if (d !== modelRead(12'h000)) begin
            errors++; $display("FAIL reload_byte got %h exp %h", d, modelRead(12'h000));
        end
    endtask

    task automatic test_reset_midload();
        logic [7:0] d;
        reloadStart = 1'b1;
        step();
        reloadStart = 1'b0;
        for (int i = 0; i < 3; i++) begin
            busM.loadValid = 1'b1; busM.loadData = 8'h11 * 8'(i + 1); busM.loadLast = 1'b0;
            step();
        end
        setIdle();
        reset = 1'b0;
        modelReset();
        repeat (2) step();
        checks++;
        if ({busM.cpuResetN, busM.loadReady} !== 2'b01) begin
            errors++; $display("FAIL midload_reset got %b exp 01", {busM.cpuResetN, busM.loadReady});
        end
        reset = 1'b1;
        busM.loadValid = 1'b1; busM.loadData = 8'h44; busM.loadLast = 1'b1;
        step();
        setIdle();
        peek(12'h000, d);
        checks++;
        if (d !== 8'h44) begin errors++; $display("FAIL midload_addr0 got %h exp 44", d); end
        peek(12'h002, d);
        checks++;
        if (d !== 8'h33) begin errors++; $display("FAIL midload_kept got %h exp 33", d); end
        step();
        #2;
        reset = 1'b0;
        #1;
        checks++;
        if ({busM.cpuResetN, busM.loadReady, halted, outPort} !== {3'b010, 8'h00}) begin
            errors++; $display("FAIL async_reset got %b/%h exp 010/00", {busM.cpuResetN, busM.loadReady, halted}, outPort);
        end
        modelReset();
        step();
        reset = 1'b1;
        step();
    endtask

    task automatic test_boundary();
        for (int i = 0; i < DEPTH_SMALL; i++) begin
            busS.loadValid = 1'b1; busS.loadData = 8'(i * 7 + 3); busS.loadLast = 1'b0;
            step();
            if (i == DEPTH_SMALL - 2) begin
                checks++;
                if ({busS.cpuResetN, busS.loadReady} !== 2'b01) begin
                    errors++; $display("FAIL bound_before got %b exp 01", {busS.cpuResetN, busS.loadReady});
                end
            end
        end
        busS.loadData = 8'hEE;
        #1;
        checks++;
        if ({busS.cpuResetN, busS.loadReady} !== 2'b10) begin
            errors++; $display("FAIL bound_full got %b exp 10", {busS.cpuResetN, busS.loadReady});
        end
        step();
        busS.loadValid = 1'b0;
        for (int i = 0; i < DEPTH_SMALL; i++) begin
            busS.addrBus = 12'(i);
            #1;
            checks++;
            if (busS.dataBus !== 8'(i * 7 + 3)) begin
                errors++; $display("FAIL bound_data addr %0d got %h exp %h", i, busS.dataBus, 8'(i * 7 + 3));
            end
            if (i % 4 == 3) step();
        end
        busS.addrBus = 12'd16;
        #1;
        checks++;
        if ({busS.dataBus, busS.loadReady, haltedS, outStrobeS, outPortS} !== {HOP, 3'b000, 8'h00}) begin
            errors++; $display("FAIL bound_unmapped got %h/%b/%b/%b/%h exp %h/0/0/0/00",
                busS.dataBus, busS.loadReady, haltedS, outStrobeS, outPortS, HOP);
        end
    endtask

    initial begin
        test_reset();
        test_load();
        test_ram_write();
        test_io();
        test_random();
        test_halt();
        test_reset_midload();
        test_boundary();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
